// File: rtl/nvme_rc_init_seq.sv
`timescale 1ns/1ps
// Root-complex bring-up sequencer: programs four bridge registers per root port over AXI-Lite.
// Optional per-write readback verification is enabled with macro NVME_INIT_READBACK_EN.
module nvme_rc_init_seq #(
  parameter logic [31:0] P0_CFG_BASE = 32'h0000_0000,
  parameter logic [31:0] P1_CFG_BASE = 32'h0001_0000,
  parameter logic [31:0] P0_BAR      = 32'hA000_0000,
  parameter logic [31:0] P1_BAR      = 32'hB000_0000,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  link_up,
  output logic [31:0] m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  err_code,
  output logic [1:0]  port_ready
);

  typedef enum logic [3:0] {
    IDLE, WAIT_LINK, WR, WAIT_B, RD, WAIT_R, NEXT, DONE, ERR
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state;
  logic [15:0] cnt;
  logic        port;
  logic [1:0]  step;
  logic        link_lost;
  logic        cur_link;
  logic        timeout;
  logic        nxt_port;
  logic [1:0]  nxt_step;
  logic [31:0] nxt_addr;
  logic [31:0] nxt_data;

  assign cur_link = link_up[port];
  assign timeout  = (cnt == CNT_LAST);
  assign m_wstrb  = 4'hF;

  assign busy  = (state != IDLE) && (state != DONE) && (state != ERR);
  assign done  = (state == DONE);
  assign error = (state == ERR);

  // Target of the next write issued from WAIT_LINK (port 0 step 0) or NEXT.
  always_comb begin
    nxt_port = port;
    nxt_step = step + 2'd1;
    if (state == WAIT_LINK || step == 2'd3) begin
      nxt_port = (state != WAIT_LINK);
      nxt_step = 2'd0;
    end
    nxt_addr = nxt_port ? P1_CFG_BASE : P0_CFG_BASE;
    nxt_data = '0;
    case (nxt_step)
      2'd0: begin nxt_addr = nxt_addr + 32'h004; nxt_data = 32'h0000_0006; end
      2'd1: begin nxt_addr = nxt_addr + 32'h010; nxt_data = nxt_port ? P1_BAR : P0_BAR; end
      2'd2: begin nxt_addr = nxt_addr + 32'h014; nxt_data = '0; end
      default: begin nxt_addr = nxt_addr + 32'h148; nxt_data = 32'h0000_0001; end
    endcase
  end

`ifndef NVME_INIT_READBACK_EN
  logic unused_rd;
  assign unused_rd = ^{m_arready, m_rvalid, m_rresp, m_rdata};
  assign m_arvalid = 1'b0;
  assign m_rready  = 1'b0;
  assign m_araddr  = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      port       <= 1'b0;
      step       <= '0;
      link_lost  <= 1'b0;
      err_code   <= '0;
      port_ready <= '0;
      m_awaddr   <= '0;
      m_awvalid  <= 1'b0;
      m_wdata    <= '0;
      m_wvalid   <= 1'b0;
      m_bready   <= 1'b0;
`ifdef NVME_INIT_READBACK_EN
      m_araddr   <= '0;
      m_arvalid  <= 1'b0;
      m_rready   <= 1'b0;
`endif
    end else begin
      if (cnt != '1) cnt <= cnt + 16'd1;
      if ((state == WR || state == WAIT_B || state == RD || state == WAIT_R) && !cur_link)
        link_lost <= 1'b1;

      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state      <= WAIT_LINK;
            cnt        <= '0;
            err_code   <= '0;
            port_ready <= '0;
            port       <= 1'b0;
            step       <= '0;
            link_lost  <= 1'b0;
          end
        end
        WAIT_LINK: begin
          if (link_up == 2'b11) begin
            state     <= WR;
            cnt       <= '0;
            m_awaddr  <= nxt_addr;
            m_wdata   <= nxt_data;
            m_awvalid <= 1'b1;
            m_wvalid  <= 1'b1;
          end else if (timeout) begin
            state    <= ERR;
            cnt      <= '0;
            err_code <= 3'd1;
          end
        end
        WR: begin
          // AW and W retire independently; B is awaited only once both have.
          if (m_awready) m_awvalid <= 1'b0;
          if (m_wready)  m_wvalid  <= 1'b0;
          if ((!m_awvalid || m_awready) && (!m_wvalid || m_wready)) begin
            state    <= WAIT_B;
            cnt      <= '0;
            m_bready <= 1'b1;
          end
        end
        WAIT_B: begin
          if (m_bvalid) begin
            m_bready <= 1'b0;
            cnt      <= '0;
            if (m_bresp != 2'b00) begin
              state    <= ERR;
              err_code <= 3'd2;
            end else if (link_lost || !cur_link) begin
              state    <= ERR;
              err_code <= 3'd6;
            end else begin
`ifdef NVME_INIT_READBACK_EN
              state     <= RD;
              m_araddr  <= m_awaddr;
              m_arvalid <= 1'b1;
`else
              state     <= NEXT;
`endif
            end
          end else if (timeout) begin
            m_bready <= 1'b0;
            state    <= ERR;
            cnt      <= '0;
            err_code <= 3'd3;
          end
        end
`ifdef NVME_INIT_READBACK_EN
        RD: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            state     <= WAIT_R;
            cnt       <= '0;
          end
        end
        WAIT_R: begin
          if (m_rvalid) begin
            m_rready <= 1'b0;
            cnt      <= '0;
            if (m_rresp != 2'b00) begin
              state    <= ERR;
              err_code <= 3'd5;
            end else if (m_rdata != m_wdata) begin
              state    <= ERR;
              err_code <= 3'd4;
            end else if (link_lost || !cur_link) begin
              state    <= ERR;
              err_code <= 3'd6;
            end else begin
              state <= NEXT;
            end
          end else if (timeout) begin
            m_rready <= 1'b0;
            state    <= ERR;
            cnt      <= '0;
            err_code <= 3'd3;
          end
        end
`endif
        NEXT: begin
          cnt <= '0;
          if (link_lost) begin
            state    <= ERR;
            err_code <= 3'd6;
          end else if (step == 2'd3 && port) begin
            port_ready[1] <= 1'b1;
            state         <= DONE;
          end else begin
            if (step == 2'd3) port_ready[0] <= 1'b1;
            port      <= nxt_port;
            step      <= nxt_step;
            state     <= WR;
            m_awaddr  <= nxt_addr;
            m_wdata   <= nxt_data;
            m_awvalid <= 1'b1;
            m_wvalid  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
